// File: rtl/ntt_twiddle_seq.sv
// Butterfly/zeta schedule sequencer for the 256-point Kyber NTT/INTT.
// Define INTT_SCALE_EN to append the 256-descriptor inverse scale pass.
module ntt_twiddle_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic       busy,
    output logic       done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] zeta_addr,
    output logic [2:0] layer,
    output logic       last,
    output logic       scale
);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
    } desc_t;

`ifdef INTT_SCALE_EN
    typedef enum logic [1:0] {IDLE, RUN, SCALE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    // len is a power of two, so g/o are a shift and a mask of the index
    function automatic desc_t calc(input logic inv,
                                   input logic [2:0] l,
                                   input logic [6:0] k);
        logic [3:0] s;
        logic [7:0] len;
        logic [7:0] g;
        logic [7:0] o;
        desc_t      d;
        s   = inv ? {1'b0, l} + 4'd1 : 4'd7 - {1'b0, l};
        len = 8'd1 << s;
        g   = {1'b0, k} >> s;
        o   = {1'b0, k} & (len - 8'd1);
        d.a = (g << (s + 4'd1)) | o;
        d.b = d.a + len;
        d.z = inv ? 7'((8'd128 >> l) - 8'd1 - g)
                  : 7'((8'd1 << l) + g);
        return d;
    endfunction

    state_t     state, state_n;
    logic       mode_q, mode_n;
    logic [7:0] idx, idx_n;
    logic [2:0] lay_n;
    logic       busy_n, done_n, valid_n;
    logic [7:0] a_n, b_n;
    logic [6:0] z_n;
    logic       last_n, scale_n;
    logic       xfer, fin, scale_on;
    desc_t      d;

`ifdef INTT_SCALE_EN
    assign scale_on = mode_q;
`else
    assign scale_on = 1'b0;
`endif

    assign xfer = out_valid & out_ready;

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        idx_n   = idx;
        lay_n   = layer;
        busy_n  = busy;
        done_n  = 1'b0;
        valid_n = out_valid;
        a_n     = addr_a;
        b_n     = addr_b;
        z_n     = zeta_addr;
        last_n  = last;
        scale_n = scale;
        fin     = 1'b0;
        d       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    mode_n  = mode;
                    idx_n   = '0;
                    lay_n   = '0;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    d       = calc(mode, 3'd0, 7'd0);
                    a_n     = d.a;
                    b_n     = d.b;
                    z_n     = d.z;
                    last_n  = 1'b0;
                    scale_n = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (layer == 3'd6 && idx == 8'd127) begin
`ifdef INTT_SCALE_EN
                        if (mode_q) begin
                            state_n = SCALE;
                            idx_n   = '0;
                            lay_n   = 3'd7;
                            a_n     = '0;
                            b_n     = '0;
                            z_n     = '0;
                            last_n  = 1'b0;
                            scale_n = 1'b1;
                        end else begin
                            fin = 1'b1;
                        end
`else
                        fin = 1'b1;
`endif
                    end else begin
                        idx_n  = {1'b0, idx[6:0] + 7'd1};
                        lay_n  = layer + {2'b0, idx == 8'd127};
                        d      = calc(mode_q, lay_n, idx_n[6:0]);
                        a_n    = d.a;
                        b_n    = d.b;
                        z_n    = d.z;
                        last_n = lay_n == 3'd6 && idx_n == 8'd127
                                 && !scale_on;
                    end
                end
            end
`ifdef INTT_SCALE_EN
            SCALE: begin
                if (xfer) begin
                    if (idx == 8'd255) begin
                        fin = 1'b1;
                    end else begin
                        idx_n  = idx + 8'd1;
                        a_n    = idx_n;
                        b_n    = idx_n;
                        last_n = idx_n == 8'd255;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        // finish is folded into the final transfer so start is taken next cycle
        if (fin) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            valid_n = 1'b0;
            done_n  = 1'b1;
            idx_n   = '0;
            lay_n   = '0;
            a_n     = '0;
            b_n     = '0;
            z_n     = '0;
            last_n  = 1'b0;
            scale_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            idx       <= '0;
            layer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            zeta_addr <= '0;
            last      <= 1'b0;
            scale     <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            idx       <= idx_n;
            layer     <= lay_n;
            busy      <= busy_n;
            done      <= done_n;
            out_valid <= valid_n;
            addr_a    <= a_n;
            addr_b    <= b_n;
            zeta_addr <= z_n;
            last      <= last_n;
            scale     <= scale_n;
        end
    end

endmodule
